verify_block: RTL and testbench
===============================

// Module: verify_block
// PURPOSE
// - Checking end of the mining protocol: given a block candidate (previous_hash, signature, amount,
//   transaction_direction, proof_of_work nonce) and the hash it claims, recompute the Pearson hash.
// - Accept only if the recomputed hash equals the claimed hash and meets the difficulty target.
// - Sits in Datapath/Verification beside the miner; the ledger control FSM uses its verdict before committing a transaction.
// PARAMETERS
// DIFF_BITS   4     number of hash MSBs that must be zero (target: hash[7:8-DIFF_BITS] == 0)
// RESET_HOLD  7     cycles hash engine reset_n is held low before each hash run (>=1)
// TIMEOUT     255   max cycles waiting for engine 'finished' after release; 8-bit counter
// PORTS
// clock                  in   1    system clock, all logic on posedge
// resetn                 in   1    asynchronous active-low reset
// start                  in   1    request verification; sampled only in IDLE
// previous_hash          in   8    previous block hash
// signature              in   8    player digital signature
// amount                 in   8    transaction amount
// transaction_direction  in   1    0: p1 pays p2, 1: p2 pays p1
// proof_of_work          in   39   nonce under test
// claimed_hash           in   8    block hash the miner produced
// random_table           in   288  Pearson table (same table the miner used); must be stable while busy
// busy                   out  1    high from cycle after accepted start until done
// done                   out  1    one-cycle pulse; verdict valid on the same cycle and held until next start
// block_ok               out  1    1 = block accepted
// reason                 out  2    00 ok, 01 difficulty fail, 10 hash mismatch, 11 engine timeout
// computed_hash          out  8    recomputed hash (0 on timeout)
// verify_count           out  16   number of accepted blocks, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset (async, resetn=0): state=IDLE; busy=0, done=0, block_ok=0, reason=00.
//   Also computed_hash=0, verify_count=0, internal regs cleared, hash engine held in reset.
// - Message = {previous_hash, amount, signature, transaction_direction, proof_of_work} (64 b, MSB first).
//   Identical packing to the miner; inputs are captured into registers on accepted start, never used live.
// - Engine: one pearson_hash64, enable=1, reset_n driven from FSM, message from captured regs.
// - FSM:
//   IDLE: start=1 -> capture inputs, go LOAD. start while not IDLE is ignored (no queueing).
//   LOAD: engine reset_n=0 for RESET_HOLD cycles (counter), then go HASH.
//   HASH: engine reset_n=1; wait counter cleared on entry.
//     - finished=1 -> latch hash to computed_hash, go CHECK.
//     - TIMEOUT cycles without finished -> reason=11, computed_hash=0, go REPORT.
//   CHECK (1 cycle):
//     - hash[7:8-DIFF_BITS] != 0 -> reason=01;
//     - else hash != claimed_hash -> reason=10;
//     - else reason=00, block_ok=1.
//     Difficulty is checked before mismatch. Go REPORT.
//   REPORT: done=1 for exactly one cycle; increment verify_count if block_ok (saturating); go IDLE.
// - Latency, start accepted at cycle 0: done at 0 + 1 + RESET_HOLD + engine latency + 2.
// - busy=1 in LOAD, HASH, CHECK, REPORT. start in the REPORT cycle is ignored; start may be issued on the first IDLE cycle.
// - block_ok/reason/computed_hash hold after done and are cleared to 0/00/0 on the next accepted start.
// - Async reset mid-run aborts immediately; no done pulse, verify_count=0.
// - verify_count at 16'hFFFF stays 16'hFFFF on further accepts.
// - A block the miner emitted after exhausting its backup counter (target not met) must yield reason=01.
// TESTING
// - T1: bench model finds nonce N with model hash H (H[7:4]=0); claimed_hash=H, start -> one done pulse, block_ok=1, reason=00, computed_hash=H, verify_count=1.
// - T2: same as T1 but claimed_hash=H^8'h01 -> block_ok=0, reason=10, computed_hash=H.
// - T3: nonce N+1 whose model hash has H[7:4]!=0, claimed=that hash -> reason=01, verify_count unchanged.
// - T4: engine finished forced low (stub) -> done exactly 1+RESET_HOLD+TIMEOUT+1 cycles after start, reason=11, computed_hash=8'h00.
// - T5: start pulsed every cycle during a run and in REPORT cycle -> exactly one done per accepted start; captured inputs unchanged by mid-run input changes.
// - T6: resetn low mid-HASH -> all outputs 0 immediately, no done; then verify_count preset path: 65536 accepts -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/verify_block_if.sv
// Request/verdict bundle between the ledger controller (master) and verify_block (slave).
interface verify_block_if;
  logic         start;
  logic [7:0]   previous_hash;
  logic [7:0]   signature;
  logic [7:0]   amount;
  logic         transaction_direction;
  logic [38:0]  proof_of_work;
  logic [7:0]   claimed_hash;
  logic [287:0] random_table;
  logic         busy;
  logic         done;
  logic         block_ok;
  logic [1:0]   reason;
  logic [7:0]   computed_hash;
  logic [15:0]  verify_count;

  modport master (
    output start, previous_hash, signature, amount, transaction_direction,
           proof_of_work, claimed_hash, random_table,
    input  busy, done, block_ok, reason, computed_hash, verify_count
  );

  modport slave (
    input  start, previous_hash, signature, amount, transaction_direction,
           proof_of_work, claimed_hash, random_table,
    output busy, done, block_ok, reason, computed_hash, verify_count
  );
endinterface

// File: rtl/verify_block.sv
// Block verifier: re-hashes a captured block candidate with a byte-serial Pearson engine
// and reports accept / difficulty fail / hash mismatch / engine timeout.
module pearson_hash64 (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_reset_n,
  input  logic         i_enable,
  input  logic [63:0]  i_message,
  input  logic [287:0] i_table,
  output logic         o_finished,
  output logic [7:0]   o_hash
);
  logic [2:0]  r_idx;
  logic [7:0]  r_hash;
  logic        r_finished;
  logic [63:0] w_msg_sh;
  logic [7:0]  w_x;
  logic [4:0]  w_sel;
  logic [7:0]  w_entry;
  logic [7:0]  w_seed;

  // One message byte per cycle, MSB first; bytes 32..35 of the table fold into the seed.
  always_comb begin
    w_msg_sh = i_message << {r_idx, 3'b000};
    w_x      = r_hash ^ w_msg_sh[63:56];
    w_sel    = w_x[4:0] ^ {2'b00, w_x[7:5]};
    w_entry  = i_table[{w_sel, 3'b000} +: 8];
    w_seed   = i_table[263:256] ^ i_table[271:264] ^ i_table[279:272] ^ i_table[287:280];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx      <= 3'd0;
      r_hash     <= 8'h00;
      r_finished <= 1'b0;
    end else if (!i_reset_n) begin
      r_idx      <= 3'd0;
      r_hash     <= w_seed;
      r_finished <= 1'b0;
    end else if (i_enable && !r_finished) begin
      r_hash <= w_entry;
      r_idx  <= r_idx + 3'd1;
      if (r_idx == 3'd7) r_finished <= 1'b1;
    end
  end

  assign o_finished = r_finished;
  assign o_hash     = r_hash;
endmodule

module verify_block #(
  parameter int unsigned DIFF_BITS   = 4,
  parameter int unsigned RESET_HOLD  = 7,
  parameter int unsigned TIMEOUT     = 255,
  parameter bit          ENGINE_STUB = 1'b0,
  parameter logic [15:0] VCOUNT_RST  = 16'h0000
) (
  input  logic          clock,
  input  logic          resetn,
  verify_block_if.slave bus
);
  // state    | meaning
  // S_IDLE   | waiting for start, verdict of last run held
  // S_LOAD   | engine held in reset for RESET_HOLD cycles
  // S_HASH   | engine running, timeout down-counter active
  // S_CHECK  | difficulty then hash-match evaluation
  // S_REPORT | done pulse, verify_count update
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HASH, S_CHECK, S_REPORT} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [63:0] r_msg, w_msg_nxt;
  logic [7:0]  r_claimed, w_claimed_nxt;
  logic [7:0]  r_comp, w_comp_nxt;
  logic        r_ok, w_ok_nxt;
  logic [1:0]  r_reason, w_reason_nxt;
  logic [15:0] r_count, w_count_nxt;
  logic        w_eng_rst_n;
  logic        w_eng_finished;
  logic        w_finished;
  logic [7:0]  w_eng_hash;

  pearson_hash64 u_engine (
    .i_clk      (clock),
    .i_rst_n    (resetn),
    .i_reset_n  (w_eng_rst_n),
    .i_enable   (1'b1),
    .i_message  (r_msg),
    .i_table    (bus.random_table),
    .o_finished (w_eng_finished),
    .o_hash     (w_eng_hash)
  );

  // ENGINE_STUB ties off finished so the timeout path can be exercised at board bring-up.
  assign w_finished = w_eng_finished & ~ENGINE_STUB;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_msg_nxt     = r_msg;
    w_claimed_nxt = r_claimed;
    w_comp_nxt    = r_comp;
    w_ok_nxt      = r_ok;
    w_reason_nxt  = r_reason;
    w_count_nxt   = r_count;
    w_eng_rst_n   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_msg_nxt     = {bus.previous_hash, bus.amount, bus.signature,
                           bus.transaction_direction, bus.proof_of_work};
          w_claimed_nxt = bus.claimed_hash;
          w_comp_nxt    = 8'h00;
          w_ok_nxt      = 1'b0;
          w_reason_nxt  = 2'b00;
          w_cnt_nxt     = 8'(RESET_HOLD - 1);
          w_state_nxt   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (r_cnt == 8'd0) begin
          w_cnt_nxt   = 8'(TIMEOUT);
          w_state_nxt = S_HASH;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_HASH: begin
        w_eng_rst_n = 1'b1;
        if (w_finished) begin
          w_comp_nxt  = w_eng_hash;
          w_state_nxt = S_CHECK;
        end else if (r_cnt == 8'd0) begin
          w_reason_nxt = 2'b11;
          w_comp_nxt   = 8'h00;
          w_state_nxt  = S_REPORT;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_CHECK: begin
        if (r_comp[7:8-DIFF_BITS] != '0) begin
          w_reason_nxt = 2'b01;
        end else if (r_comp != r_claimed) begin
          w_reason_nxt = 2'b10;
        end else begin
          w_reason_nxt = 2'b00;
          w_ok_nxt     = 1'b1;
        end
        w_state_nxt = S_REPORT;
      end
      S_REPORT: begin
        if (r_ok && (r_count != 16'hFFFF)) w_count_nxt = r_count + 16'd1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_msg     <= 64'd0;
      r_claimed <= 8'h00;
      r_comp    <= 8'h00;
      r_ok      <= 1'b0;
      r_reason  <= 2'b00;
      r_count   <= VCOUNT_RST;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_msg     <= w_msg_nxt;
      r_claimed <= w_claimed_nxt;
      r_comp    <= w_comp_nxt;
      r_ok      <= w_ok_nxt;
      r_reason  <= w_reason_nxt;
      r_count   <= w_count_nxt;
    end
  end

  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = (r_state == S_REPORT);
  assign bus.block_ok      = r_ok;
  assign bus.reason        = r_reason;
  assign bus.computed_hash = r_comp;
  assign bus.verify_count  = r_count;
endmodule

// File: tb/tb_verify_block.sv
// Directed bench for verify_block: accept, mismatch, difficulty, timeout, start filtering,
// mid-run reset and verify_count saturation.
module tb_verify_block;
  localparam int RH = 7;
  localparam int TO = 255;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [7:0]   ph, sig, amt;
  logic         dir;
  logic [287:0] tbl;
  logic [38:0]  n_good;
  logic [7:0]   h_good, h_bad;

  verify_block_if bus();
  verify_block_if bus_stub();
  verify_block_if bus_sat();

  verify_block dut (.clock(clk), .resetn(rst_n), .bus(bus.slave));
  verify_block #(.ENGINE_STUB(1'b1)) dut_stub (.clock(clk), .resetn(rst_n), .bus(bus_stub.slave));
  verify_block #(.VCOUNT_RST(16'hFFFD)) dut_sat (.clock(clk), .resetn(rst_n), .bus(bus_sat.slave));

  assign bus_stub.previous_hash         = bus.previous_hash;
  assign bus_stub.signature             = bus.signature;
  assign bus_stub.amount                = bus.amount;
  assign bus_stub.transaction_direction = bus.transaction_direction;
  assign bus_stub.proof_of_work         = bus.proof_of_work;
  assign bus_stub.claimed_hash          = bus.claimed_hash;
  assign bus_stub.random_table          = bus.random_table;
  assign bus_sat.previous_hash          = bus.previous_hash;
  assign bus_sat.signature              = bus.signature;
  assign bus_sat.amount                 = bus.amount;
  assign bus_sat.transaction_direction  = bus.transaction_direction;
  assign bus_sat.proof_of_work          = bus.proof_of_work;
  assign bus_sat.claimed_hash           = bus.claimed_hash;
  assign bus_sat.random_table           = bus.random_table;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Pearson hash: seed is the XOR of table bytes 32..35, each step looks up
  // T[x[4:0] ^ x[7:5]] with x = h ^ byte, bytes taken MSB first.
  function automatic logic [7:0] model_hash(input logic [38:0] pow);
    logic [63:0] msg;
    logic [7:0]  h, x, b;
    logic [4:0]  s;
    msg = {ph, amt, sig, dir, pow};
    h = tbl[263:256] ^ tbl[271:264] ^ tbl[279:272] ^ tbl[287:280];
    for (int i = 0; i < 8; i++) begin
      b = msg[63 - 8*i -: 8];
      x = h ^ b;
      s = x[4:0] ^ {2'b00, x[7:5]};
      h = tbl[8*s +: 8];
    end
    return h;
  endfunction

  function automatic logic done_of(input int which);
    case (which)
      0:       return bus.done;
      1:       return bus_stub.done;
      default: return bus_sat.done;
    endcase
  endfunction

  task automatic set_inputs(input logic [38:0] pow, input logic [7:0] claimed);
    bus.previous_hash         = ph;
    bus.signature             = sig;
    bus.amount                = amt;
    bus.transaction_direction = dir;
    bus.proof_of_work         = pow;
    bus.claimed_hash          = claimed;
    bus.random_table          = tbl;
  endtask

  // Leaves the bench #1 after the edge that samples start.
  task automatic pulse_start(input int which);
    case (which)
      0:       bus.start = 1'b1;
      1:       bus_stub.start = 1'b1;
      default: bus_sat.start = 1'b1;
    endcase
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus_stub.start = 1'b0;
    bus_sat.start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int limit, output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (n < limit && !got) begin
      @(posedge clk); #1;
      n++;
      if (done_of(which)) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus_stub.start = 1'b0;
    bus_sat.start = 1'b0;
    set_inputs(39'd0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.block_ok} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: busy/done/ok got %b expected 000", {bus.busy, bus.done, bus.block_ok});
    end
    tests++;
    if (bus.reason !== 2'b00) begin
      fails++;
      $display("FAIL reset_reason: got %b expected 00", bus.reason);
    end
    tests++;
    if (bus.computed_hash !== 8'h00 || bus.verify_count !== 16'h0000) begin
      fails++;
      $display("FAIL reset_regs: hash %h count %h expected 00 0000", bus.computed_hash, bus.verify_count);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_accept;
    int n;
    bit got;
    set_inputs(n_good, h_good);
    pulse_start(0);
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL t1_busy: got %b expected 1", bus.busy);
    end
    wait_done(0, 40, n, got);
    tests++;
    if (!got || n + 1 != 1 + RH + 8 + 2) begin
      fails++;
      $display("FAIL t1_latency: done got=%0d at cycle %0d expected cycle %0d", got, n + 1, 1 + RH + 8 + 2);
    end
    tests++;
    if ({bus.block_ok, bus.reason, bus.computed_hash} !== {1'b1, 2'b00, h_good}) begin
      fails++;
      $display("FAIL t1_verdict: ok %b reason %b hash %h expected 1 00 %h",
               bus.block_ok, bus.reason, bus.computed_hash, h_good);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.done !== 1'b0 || bus.verify_count !== 16'd1) begin
      fails++;
      $display("FAIL t1_after: done %b count %0d expected 0 1", bus.done, bus.verify_count);
    end
  endtask

  task automatic test_mismatch;
    int n;
    bit got;
    set_inputs(n_good, h_good ^ 8'h01);
    pulse_start(0);
    wait_done(0, 40, n, got);
    tests++;
    if (!got || {bus.block_ok, bus.reason, bus.computed_hash} !== {1'b0, 2'b10, h_good}) begin
      fails++;
      $display("FAIL t2_mismatch: done %0d ok %b reason %b hash %h expected 1 0 10 %h",
               got, bus.block_ok, bus.reason, bus.computed_hash, h_good);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.verify_count !== 16'd1) begin
      fails++;
      $display("FAIL t2_count: got %0d expected 1", bus.verify_count);
    end
  endtask

  task automatic test_difficulty;
    int n;
    bit got;
    set_inputs(n_good + 39'd1, h_bad);
    pulse_start(0);
    wait_done(0, 40, n, got);
    tests++;
    if (!got || {bus.block_ok, bus.reason, bus.computed_hash} !== {1'b0, 2'b01, h_bad}) begin
      fails++;
      $display("FAIL t3_difficulty: done %0d ok %b reason %b hash %h expected 1 0 01 %h",
               got, bus.block_ok, bus.reason, bus.computed_hash, h_bad);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.verify_count !== 16'd1) begin
      fails++;
      $display("FAIL t3_count: got %0d expected 1", bus.verify_count);
    end
  endtask

  task automatic test_timeout;
    int n;
    bit got;
    set_inputs(n_good, h_good);
    pulse_start(1);
    wait_done(1, 400, n, got);
    tests++;
    if (!got || n + 1 != 1 + RH + TO + 1) begin
      fails++;
      $display("FAIL t4_latency: done got=%0d at cycle %0d expected cycle %0d", got, n + 1, 1 + RH + TO + 1);
    end
    tests++;
    if ({bus_stub.block_ok, bus_stub.reason, bus_stub.computed_hash} !== {1'b0, 2'b11, 8'h00}) begin
      fails++;
      $display("FAIL t4_verdict: ok %b reason %b hash %h expected 0 11 00",
               bus_stub.block_ok, bus_stub.reason, bus_stub.computed_hash);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    int dones;
    bit got;
    dones = 0;
    set_inputs(n_good, h_good);
    bus.start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      bus.proof_of_work = bus.proof_of_work + 39'd3;
      bus.claimed_hash  = bus.claimed_hash ^ 8'h5A;
      bus.previous_hash = bus.previous_hash ^ 8'h01;
      @(posedge clk); #1;
      n++;
      if (bus.done) begin
        got = 1'b1;
        dones++;
      end
    end
    tests++;
    if (!got || {bus.block_ok, bus.reason, bus.computed_hash} !== {1'b1, 2'b00, h_good}) begin
      fails++;
      $display("FAIL t5_capture: done %0d ok %b reason %b hash %h expected 1 1 00 %h",
               got, bus.block_ok, bus.reason, bus.computed_hash, h_good);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL t5_report_start: busy %b done %b expected 0 0", bus.busy, bus.done);
    end
    set_inputs(n_good, h_good ^ 8'h01);
    @(posedge clk); #1;
    bus.start = 1'b0;
    tests++;
    if ({bus.busy, bus.block_ok, bus.reason, bus.computed_hash} !== {1'b1, 1'b0, 2'b00, 8'h00}) begin
      fails++;
      $display("FAIL t5_first_idle: busy %b ok %b reason %b hash %h expected 1 0 00 00",
               bus.busy, bus.block_ok, bus.reason, bus.computed_hash);
    end
    wait_done(0, 40, n, got);
    if (got) dones++;
    tests++;
    if (!got || n + 1 != 1 + RH + 8 + 2 || bus.reason !== 2'b10 || bus.computed_hash !== h_good) begin
      fails++;
      $display("FAIL t5_second: done %0d cycle %0d reason %b hash %h expected 1 %0d 10 %h",
               got, n + 1, bus.reason, bus.computed_hash, 1 + RH + 8 + 2, h_good);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    tests++;
    if (dones != 2 || bus.verify_count !== 16'd2) begin
      fails++;
      $display("FAIL t5_pulses: dones %0d count %0d expected 2 2", dones, bus.verify_count);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    dones = 0;
    set_inputs(n_good, h_good);
    pulse_start(0);
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL t6_busy: got %b expected 1", bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.block_ok, bus.reason, bus.computed_hash, bus.verify_count} !== 29'd0) begin
      fails++;
      $display("FAIL t6_reset_now: busy %b done %b ok %b reason %b hash %h count %h expected all 0",
               bus.busy, bus.done, bus.block_ok, bus.reason, bus.computed_hash, bus.verify_count);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    tests++;
    if (dones != 0 || bus.verify_count !== 16'd0) begin
      fails++;
      $display("FAIL t6_no_done: dones %0d count %0d expected 0 0", dones, bus.verify_count);
    end
  endtask

  task automatic test_saturate;
    int n;
    bit got;
    logic [15:0] exp_cnt;
    exp_cnt = 16'hFFFD;
    set_inputs(n_good, h_good);
    for (int k = 0; k < 3; k++) begin
      pulse_start(2);
      wait_done(2, 40, n, got);
      @(posedge clk); #1;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      tests++;
      if (!got || bus_sat.block_ok !== 1'b1 || bus_sat.verify_count !== exp_cnt) begin
        fails++;
        $display("FAIL t6_saturate_%0d: done %0d ok %b count %h expected 1 1 %h",
                 k, got, bus_sat.block_ok, bus_sat.verify_count, exp_cnt);
      end
    end
  endtask

  initial begin
    bit found;
    tests = 0;
    fails = 0;
    ph  = 8'hA5;
    sig = 8'h3C;
    amt = 8'h64;
    dir = 1'b1;
    for (int i = 0; i < 36; i++) tbl[8*i +: 8] = 8'((i * 97 + 53) ^ (i * 13));
    tbl[8*5 +: 8]  = 8'h0A;
    tbl[8*20 +: 8] = 8'h03;
    tbl[8*27 +: 8] = 8'h07;
    found  = 1'b0;
    n_good = 39'd0;
    for (int k = 0; k < 4096 && !found; k++) begin
      if (model_hash(39'(k))[7:4] == 4'h0 && model_hash(39'(k + 1))[7:4] != 4'h0) begin
        n_good = 39'(k);
        found  = 1'b1;
      end
    end
    h_good = model_hash(n_good);
    h_bad  = model_hash(n_good + 39'd1);
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL nonce_search: found %0d expected 1", found);
    end

    test_reset();
    test_accept();
    test_mismatch();
    test_difficulty();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_saturate();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
